mem_sp_clr: RTL and testbench
=============================

MEM_SP_CLR -- requirements
Module: mem_sp_clr

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (>=1) SHALL be supported.
REQ-002 Parameter ADDR_W, default 6, address width in bits (>=1) SHALL be supported.
REQ-003 Parameter DEPTH, default 64, number of stored words, 2 <= DEPTH <= 2**ADDR_W, SHALL be supported.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 clr  input  1  request to zero the whole array.
REQ-007 we  input  1  write enable.
REQ-008 re  input  1  read enable.
REQ-009 addr  input  ADDR_W  word address for read or write.
REQ-010 din  input  DATA_W  write data.
REQ-011 dout  output  DATA_W  registered read data; holds its value between reads.
REQ-012 dout_valid  output  1  one-cycle pulse; dout was updated by a read this edge.
REQ-013 busy  output  1  high while the clear engine owns the array.
REQ-014 rej  output  1  one-cycle pulse; a we or re was dropped.

Function
REQ-015 The block SHALL have two states, CLEAR and IDLE; busy SHALL equal (state==CLEAR).
REQ-016 In CLEAR, the block SHALL write 0 to location clr_cnt each edge and increment clr_cnt (width ADDR_W).
REQ-017 When a CLEAR write targets DEPTH-1, the state SHALL become IDLE at that edge; a clear therefore lasts exactly DEPTH edges.
REQ-018 In IDLE, clr=1 SHALL move to CLEAR with clr_cnt=0; clr=1 while in CLEAR SHALL be ignored (no restart).
REQ-019 In IDLE with clr=0 and we=1, addr<DEPTH: mem[addr] SHALL take din at that edge.
REQ-020 In IDLE with clr=0, re=1, we=0: dout SHALL take mem[addr] and dout_valid SHALL pulse at that edge (1-cycle latency).
REQ-021 we and re in the same IDLE cycle: the write SHALL occur; the read SHALL NOT occur; rej SHALL stay 0.
REQ-022 Read of addr>=DEPTH SHALL return 0 with dout_valid=1; write to addr>=DEPTH SHALL be discarded silently.
REQ-023 Any we or re sampled while in CLEAR, or together with clr in IDLE, SHALL be dropped and rej SHALL pulse for one cycle.
REQ-024 dout SHALL change only on an accepted read; clear activity SHALL NOT alter dout.
REQ-025 A read following a write to the same address on the previous edge SHALL return the new data.

Reset
REQ-026 rst_n=0 SHALL immediately force: state=CLEAR, clr_cnt=0, dout=0, dout_valid=0, rej=0, busy=1.
REQ-027 The array SHALL NOT be asynchronously reset; it SHALL be zeroed by the CLEAR sequence that starts when rst_n rises.
REQ-028 rst_n asserted mid-clear or mid-access SHALL abandon that operation and restart the full clear on release.

Verification
REQ-029 Defaults; release rst_n -> busy=1 for exactly 64 edges, then 0; read of every addr 0..63 -> dout=0x00, dout_valid pulse each.
REQ-030 IDLE: write 0xA5 to addr 5, next cycle re addr 5 -> dout=0xA5 one edge later, dout_valid one cycle high.
REQ-031 IDLE: we=1,re=1,addr=9,din=0x3C -> dout unchanged, dout_valid=0; subsequent read of 9 -> 0x3C.
REQ-032 After filling addr 0..63 with 0xFF, pulse clr -> busy high 64 edges; we to addr 3 at clear edge 10 -> rej=1, data dropped; afterwards all reads 0x00, dout unchanged until first read.
REQ-033 DEPTH=40, ADDR_W=6: write 0x77 to addr 45 -> discarded; read 45 -> 0x00 valid; clear lasts 40 edges.
REQ-034 Drop rst_n at clear edge 20 while dout=0x5A -> dout=0x00, busy=1 immediately; after release clear restarts at 0 and lasts 64 edges.

Source files
------------

// File: rtl/mem_sp_clr.sv
// Single-port word memory with a self-timed clear engine.
// After reset release, or on a clr request, the array is zeroed one word per
// clock. Reads and writes are accepted only while idle and clr is low;
// anything else is dropped and flagged on rej.
module mem_sp_clr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              rej
);

  // Address limit held one bit wider so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Reject illegal geometry at elaboration.
  if (DATA_W < 1 || ADDR_W < 1 || DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_param_check
    $error("mem_sp_clr: illegal DATA_W/ADDR_W/DEPTH combination");
  end

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   clr_cnt_nxt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range_c;
  logic                clr_last_c;
  logic [DATA_W-1:0]   rd_data_c;

  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_waddr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  logic [DATA_W-1:0]   dout_nxt;
  logic                dout_valid_nxt;
  logic                rej_nxt;

  // Address decode and clear-sweep terminal detect.
  assign in_range_c = ({1'b0, addr} < DEPTH_X);
  assign clr_last_c = (clr_cnt == LAST_ADDR);
  assign rd_data_c  = in_range_c ? mem[addr] : '0;

  assign busy = (state == ST_CLEAR);

  // State and clear-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: sweep to the last word, then idle; clr restarts only from idle.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    unique case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_last_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: array write port, read data, valid and reject pulses.
  always_comb begin
    mem_we_c       = 1'b0;
    mem_waddr_c    = addr;
    mem_wdata_c    = din;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
    rej_nxt        = 1'b0;
    if (state == ST_CLEAR) begin
      // Clear engine owns the port; any host access is dropped.
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_cnt;
      mem_wdata_c = '0;
      rej_nxt     = we | re;
    end else if (clr) begin
      // Access arriving with a clear request is dropped.
      rej_nxt = we | re;
    end else if (we) begin
      // Write wins over a simultaneous read; out-of-range writes vanish.
      mem_we_c = in_range_c;
    end else if (re) begin
      dout_nxt       = rd_data_c;
      dout_valid_nxt = 1'b1;
    end
  end

  // Storage array: no reset, zeroed by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      rej        <= 1'b0;
    end else begin
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      rej        <= rej_nxt;
    end
  end

endmodule

// File: tb/tb_mem_sp_clr.sv
// Directed bench for mem_sp_clr: default geometry plus a DEPTH=40 instance.
module tb_mem_sp_clr;

  logic       clk = 1'b0;

  logic       rst_n = 1'b1;
  logic       clr   = 1'b0;
  logic       we    = 1'b0;
  logic       re    = 1'b0;
  logic [5:0] addr  = '0;
  logic [7:0] din   = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       rej;

  logic       rst_n2 = 1'b1;
  logic       clr2   = 1'b0;
  logic       we2    = 1'b0;
  logic       re2    = 1'b0;
  logic [5:0] addr2  = '0;
  logic [7:0] din2   = '0;
  logic [7:0] dout2;
  logic       dout_valid2;
  logic       busy2;
  logic       rej2;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  mem_sp_clr u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .we         (we),
    .re         (re),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .rej        (rej)
  );

  mem_sp_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(40)) u_dut40 (
    .clk        (clk),
    .rst_n      (rst_n2),
    .clr        (clr2),
    .we         (we2),
    .re         (re2),
    .addr       (addr2),
    .din        (din2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .busy       (busy2),
    .rej        (rej2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset of both instances
    #1;
    rst_n  = 1'b0;
    rst_n2 = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_rej", 32'(rej), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check("clr_start_busy", 32'(busy), 32'd1);

    // Initial clear must last exactly 64 edges
    n = 0;
    while (busy && n < 500) begin
      tick;
      n++;
    end
    check("init_clear_len", 32'(n), 32'd64);

    // Every word reads back zero
    for (int i = 0; i < 64; i++) begin
      re   = 1'b1;
      addr = 6'(i);
      tick;
      check($sformatf("init_rd%0d_data", i), 32'(dout), 32'h00);
      check($sformatf("init_rd%0d_valid", i), 32'(dout_valid), 32'd1);
    end
    re = 1'b0;
    tick;
    check("valid_drop", 32'(dout_valid), 32'd0);

    // Write then read back on the next cycle
    we = 1'b1; addr = 6'd5; din = 8'hA5;
    tick;
    check("wr5_valid", 32'(dout_valid), 32'd0);
    we = 1'b0; re = 1'b1;
    tick;
    check("rd5_data", 32'(dout), 32'hA5);
    check("rd5_valid", 32'(dout_valid), 32'd1);
    re = 1'b0;
    tick;
    check("rd5_pulse_end", 32'(dout_valid), 32'd0);
    check("rd5_hold", 32'(dout), 32'hA5);

    // Simultaneous write and read: write wins, no read, no reject
    we = 1'b1; re = 1'b1; addr = 6'd9; din = 8'h3C;
    tick;
    check("wr_rd_dout", 32'(dout), 32'hA5);
    check("wr_rd_valid", 32'(dout_valid), 32'd0);
    check("wr_rd_rej", 32'(rej), 32'd0);
    we = 1'b0;
    tick;
    check("rd9_data", 32'(dout), 32'h3C);
    check("rd9_valid", 32'(dout_valid), 32'd1);
    re = 1'b0;

    // Fill all words with 0xFF
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; addr = 6'(i); din = 8'hFF;
      tick;
    end
    we = 1'b0;
    re = 1'b1; addr = 6'd33;
    tick;
    check("fill_rd33", 32'(dout), 32'hFF);
    re = 1'b0; addr = 6'd9;
    tick;

    // Clear request arriving with a write: write dropped, clear starts
    clr = 1'b1; we = 1'b1; addr = 6'd2; din = 8'h55;
    tick;
    check("clr_req_busy", 32'(busy), 32'd1);
    check("clr_req_rej", 32'(rej), 32'd1);
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    // Write at clear edge 10 is rejected
    we = 1'b1; addr = 6'd3; din = 8'hEE;
    tick;
    check("clr_we_rej", 32'(rej), 32'd1);
    check("clr_we_dout", 32'(dout), 32'hFF);
    check("clr_we_valid", 32'(dout_valid), 32'd0);
    we = 1'b0;
    tick;
    check("clr_rej_pulse_end", 32'(rej), 32'd0);
    // clr while clearing must not restart the sweep (edge 12)
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      tick;
      n++;
    end
    check("clr_remaining_len", 32'(n), 32'd52);
    check("clr_dout_kept", 32'(dout), 32'hFF);
    check("clr_valid_low", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 64; i++) begin
      re = 1'b1; addr = 6'(i);
      tick;
      check($sformatf("post_clr_rd%0d", i), 32'(dout), 32'h00);
    end
    re = 1'b0;

    // Reset mid-clear while dout holds 0x5A
    we = 1'b1; addr = 6'd10; din = 8'h5A;
    tick;
    we = 1'b0; re = 1'b1;
    tick;
    check("rd10_5a", 32'(dout), 32'h5A);
    re = 1'b0;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    check("mid_clr_busy", 32'(busy), 32'd1);
    check("mid_clr_dout", 32'(dout), 32'h5A);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_busy", 32'(busy), 32'd1);
    tick;
    tick;
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 500) begin
      tick;
      n++;
    end
    check("restart_clear_len", 32'(n), 32'd64);
    re = 1'b1; addr = 6'd10;
    tick;
    check("restart_rd10", 32'(dout), 32'h00);
    check("restart_rd10_valid", 32'(dout_valid), 32'd1);
    re = 1'b0;

    // DEPTH=40 instance
    rst_n2 = 1'b1;
    n = 0;
    while (busy2 && n < 500) begin
      tick;
      n++;
    end
    check("d40_clear_len", 32'(n), 32'd40);
    we2 = 1'b1; addr2 = 6'd45; din2 = 8'h77;
    tick;
    check("d40_wr45_rej", 32'(rej2), 32'd0);
    we2 = 1'b0; re2 = 1'b1;
    tick;
    check("d40_rd45_data", 32'(dout2), 32'h00);
    check("d40_rd45_valid", 32'(dout_valid2), 32'd1);
    re2 = 1'b0; we2 = 1'b1; addr2 = 6'd39; din2 = 8'h66;
    tick;
    we2 = 1'b0; re2 = 1'b1;
    tick;
    check("d40_rd39_data", 32'(dout2), 32'h66);
    addr2 = 6'd40;
    tick;
    check("d40_rd40_data", 32'(dout2), 32'h00);
    check("d40_rd40_valid", 32'(dout_valid2), 32'd1);
    re2 = 1'b0;
    clr2 = 1'b1;
    tick;
    clr2 = 1'b0;
    n = 0;
    while (busy2 && n < 500) begin
      tick;
      n++;
    end
    check("d40_clr_len", 32'(n), 32'd40);
    re2 = 1'b1; addr2 = 6'd39;
    tick;
    check("d40_post_clr_rd39", 32'(dout2), 32'h00);
    re2 = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
